// File: rtl/mq_pkg.sv
// Shared FSM encoding and header layout for the message-queue read arbiter.
package mq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR_RD,
        HDR_LEN,
        PAYLOAD
    } mq_state_t;

    localparam int HDR_LEN_LSB = 0;

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority select: first asserted request strictly after ptr, wrapping.
module rr_pick #(
    parameter int NUM_Q = 4,
    parameter int QID_W = $clog2(NUM_Q)
) (
    input  logic [NUM_Q-1:0] req,
    input  logic [QID_W-1:0] ptr,
    output logic [QID_W-1:0] gnt_idx,
    output logic             any
);

    always_comb begin
        int idx;
        gnt_idx = '0;
        any     = |req;
        idx     = 0;
        // Walk from the farthest candidate back to the nearest so the nearest wins.
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            idx = (int'(ptr) + 1 + k) % NUM_Q;
            if (req[idx]) begin
                gnt_idx = QID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mq_fifo_arbiter.sv
// Round-robin read arbiter sharing one message port between NUM_Q message FIFOs;
// a grant is held for a whole header+payload message.
module mq_fifo_arbiter
    import mq_pkg::*;
#(
    parameter int NUM_Q  = 4,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 8,
    parameter int QID_W  = $clog2(NUM_Q)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_Q-1:0]        q_empty,
    output logic [NUM_Q-1:0]        q_rd_en,
    input  logic [NUM_Q*DATA_W-1:0] q_dout,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    output logic [QID_W-1:0]        m_qid,
    output logic                    busy
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [QID_W-1:0]  qid;
    } mq_word_t;

    mq_state_t         state_reg, state_next;
    logic [QID_W-1:0]  g_reg, g_next;
    logic [QID_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [LEN_W-1:0]  rem_reg, rem_next;
    logic              inflight_reg;
    logic              infl_hdr_reg;
    logic              infl_last_reg;
    logic [QID_W-1:0]  infl_qid_reg;

    mq_word_t          buf_mem [2];
    logic              wr_ptr_reg, rd_ptr_reg;
    logic [1:0]        count_reg;

    logic [DATA_W-1:0] q_word [NUM_Q];
    logic [DATA_W-1:0] ret_word;
    logic [LEN_W-1:0]  hdr_len;
    logic [QID_W-1:0]  pick_idx;
    logic              pick_any;
    logic              credit_ok, rd_ok, rd_fire, rd_last;
    logic              push, pop;
    mq_word_t          push_word, head;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_Q; gi++) begin : g_queue
            assign q_word[gi]  = q_dout[gi*DATA_W +: DATA_W];
            assign q_rd_en[gi] = rd_fire && (g_reg == QID_W'(gi));
        end
    endgenerate

    rr_pick #(
        .NUM_Q (NUM_Q),
        .QID_W (QID_W)
    ) u_rr_pick (
        .req     (~q_empty),
        .ptr     (rr_ptr_reg),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Word returned this cycle belongs to whichever read was issued last cycle.
    assign ret_word  = q_word[infl_qid_reg];
    assign hdr_len   = ret_word[HDR_LEN_LSB +: LEN_W];
    assign credit_ok = (count_reg + {1'b0, inflight_reg}) < 2'd2;
    assign rd_ok     = !q_empty[g_reg] && credit_ok;

    always_comb begin
        state_next  = state_reg;
        g_next      = g_reg;
        rr_ptr_next = rr_ptr_reg;
        rem_next    = rem_reg;
        rd_fire     = 1'b0;
        rd_last     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    g_next      = pick_idx;
                    rr_ptr_next = pick_idx;
                    state_next  = HDR_RD;
                end
            end
            HDR_RD: begin
                if (rd_ok) begin
                    rd_fire    = 1'b1;
                    state_next = HDR_LEN;
                end
            end
            HDR_LEN: begin
                rem_next   = hdr_len;
                state_next = (hdr_len == '0) ? IDLE : PAYLOAD;
            end
            PAYLOAD: begin
                if (rd_ok) begin
                    rd_fire  = 1'b1;
                    rd_last  = (rem_reg == LEN_W'(1));
                    rem_next = rem_reg - LEN_W'(1);
                    if (rem_reg == LEN_W'(1)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            g_reg         <= '0;
            rr_ptr_reg    <= QID_W'(NUM_Q - 1);
            rem_reg       <= '0;
            inflight_reg  <= 1'b0;
            infl_hdr_reg  <= 1'b0;
            infl_last_reg <= 1'b0;
            infl_qid_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            g_reg         <= g_next;
            rr_ptr_reg    <= rr_ptr_next;
            rem_reg       <= rem_next;
            inflight_reg  <= rd_fire;
            infl_hdr_reg  <= rd_fire && (state_reg == HDR_RD);
            infl_last_reg <= rd_last;
            infl_qid_reg  <= g_reg;
        end
    end

    assign push           = inflight_reg;
    assign pop            = m_valid && m_ready;
    assign push_word.data = ret_word;
    assign push_word.last = infl_hdr_reg ? (hdr_len == '0) : infl_last_reg;
    assign push_word.qid  = infl_qid_reg;

    // The credit rule guarantees a push never lands on a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr_reg] <= push_word;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head    = buf_mem[rd_ptr_reg];
    assign m_valid = (count_reg != '0);
    assign m_data  = head.data;
    assign m_last  = head.last;
    assign m_qid   = head.qid;
    assign busy    = (state_reg != IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_mq_fifo_arbiter.sv
// Bench: FIFO models feed the arbiter; a per-queue message scoreboard checks every output word.
module tb_mq_fifo_arbiter;

    localparam int NUM_Q  = 4;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 8;
    localparam int QID_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_Q-1:0]        q_empty = '1;
    logic [NUM_Q-1:0]        q_rd_en;
    logic [NUM_Q*DATA_W-1:0] q_dout = '0;
    logic                    m_valid;
    logic                    m_ready = 1'b1;
    logic [DATA_W-1:0]       m_data;
    logic                    m_last;
    logic [QID_W-1:0]        m_qid;
    logic                    busy;

    mq_fifo_arbiter #(
        .NUM_Q  (NUM_Q),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .q_empty (q_empty),
        .q_rd_en (q_rd_en),
        .q_dout  (q_dout),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_qid   (m_qid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                q;
        logic [DATA_W-1:0] w;
    } push_t;

    logic [DATA_W-1:0] fq    [NUM_Q][$];
    logic [DATA_W-1:0] exp_q [NUM_Q][$];
    push_t             push_q[$];
    int                rd_cnt[NUM_Q];

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int lasts  = 0;
    int out_cnt = 0;
    int msg_order[$];
    int rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NUM_Q; i++) begin
            if (fq[i].size() != 0 || exp_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    // Upstream FIFOs: standard mode, dout one cycle after rd_en, reset together with the DUT.
    initial begin
        push_t p;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < NUM_Q; i++) fq[i].delete();
                q_empty <= '1;
                q_dout  <= '0;
            end else begin
                for (int i = 0; i < NUM_Q; i++) begin
                    if (q_rd_en[i] && fq[i].size() > 0) begin
                        q_dout[i*DATA_W +: DATA_W] <= fq[i].pop_front();
                        rd_cnt[i]++;
                    end
                end
                while (push_q.size() > 0) begin
                    p = push_q.pop_front();
                    fq[p.q].push_back(p.w);
                end
                for (int i = 0; i < NUM_Q; i++) q_empty[i] <= (fq[i].size() == 0);
            end
        end
    end

    // Downstream ready: steady, 1-0-0-1 pattern, or random.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: each message must be the next header+payload of its queue, unbroken.
    initial begin
        bit                in_msg = 1'b0;
        int                cur_q = 0;
        int                rem = 0;
        bit                exp_last;
        bit                prev_stall = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        logic              prev_last = 1'b0;
        logic [QID_W-1:0]  prev_qid = '0;
        logic [DATA_W-1:0] ew;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_msg     = 1'b0;
                out_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(m_valid), 64'd1);
                    chk("hold_data", m_data, prev_data);
                    chk("hold_last", 64'(m_last), 64'(prev_last));
                    chk("hold_qid", 64'(m_qid), 64'(prev_qid));
                end
                if (q_rd_en != '0) begin
                    chk("rd_onehot", 64'($onehot(q_rd_en)), 64'd1);
                    chk("rd_nonempty", 64'((q_rd_en & q_empty) == '0), 64'd1);
                    out_cnt += $countones(q_rd_en);
                    chk("credit_le2", 64'(out_cnt <= 2), 64'd1);
                end
                if (m_valid && m_ready) begin
                    if (!in_msg) begin
                        cur_q = int'(m_qid);
                        msg_order.push_back(cur_q);
                    end else begin
                        chk("msg_qid", 64'(m_qid), 64'(cur_q));
                    end
                    chk("word_available", 64'(exp_q[m_qid].size() != 0), 64'd1);
                    if (exp_q[m_qid].size() != 0) begin
                        ew = exp_q[m_qid].pop_front();
                        chk("data", m_data, ew);
                        if (!in_msg) rem = int'(ew[LEN_W-1:0]);
                        else         rem = rem - 1;
                        exp_last = (rem == 0);
                        chk("last", 64'(m_last), 64'(exp_last));
                        in_msg = !exp_last;
                    end
                    xfers++;
                    if (m_last) lasts++;
                    out_cnt--;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                prev_qid   = m_qid;
            end
        end
    end

    task automatic stage(input int q, input logic [DATA_W-1:0] w);
        push_q.push_back('{q: q, w: w});
        exp_q[q].push_back(w);
    endtask

    task automatic stage_msg(input int q, input int len);
        stage(q, {32'($urandom()), 16'(16'hA000 + q), 8'h00, 8'(len)});
        for (int k = 0; k < len; k++) stage(q, {32'($urandom()), 32'($urandom())});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (push_q.size() == 0) && !busy && (out_cnt == 0) && all_empty();
        end
        chk({name, "_drain"}, 64'(done), 64'd1);
    endtask

    task automatic chk_order(input string name, input int e0, input int e1, input int e2, input int e3, input int n);
        int ev[4];
        ev = '{e0, e1, e2, e3};
        chk({name, "_count"}, 64'(msg_order.size()), 64'(n));
        if (msg_order.size() == n) begin
            for (int k = 0; k < n; k++) chk({name, "_qid"}, 64'(msg_order[k]), 64'(ev[k]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_x, base_l, base_rd;
        // Reset state
        rst = 1'b1;
        cyc(2);
        chk("rst_rd_en", 64'(q_rd_en), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_qid", 64'(m_qid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        cyc(2);

        // Four len=0 messages, all pending together: grant order 0,1,2,3
        msg_order.delete();
        base_l = lasts;
        for (int q = 0; q < NUM_Q; q++) stage_msg(q, 0);
        drain("rr4", 200);
        chk_order("rr4", 0, 1, 2, 3, 4);
        chk("rr4_lasts", 64'(lasts - base_l), 64'd4);

        // Pointer left at 3: with 3 and 0 pending, 0 goes first
        cyc(1);
        msg_order.delete();
        stage_msg(3, 0);
        stage_msg(0, 0);
        drain("rrptr", 200);
        chk_order("rrptr", 0, 3, 0, 0, 2);

        // Single queue, len=3: 4 words, first m_valid 3 cycles after q_empty falls
        cyc(1);
        msg_order.delete();
        base_x = xfers;
        base_l = lasts;
        stage_msg(0, 3);
        n = 0;
        while (q_empty[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_latency", 64'(n), 64'd3);
        drain("len3", 200);
        chk("len3_words", 64'(xfers - base_x), 64'd4);
        chk("len3_lasts", 64'(lasts - base_l), 64'd1);
        chk_order("len3", 0, 0, 0, 0, 1);

        // q1 len=2 and q2 len=1 under ready pattern 1,0,0,1
        cyc(1);
        rdy_mode = 1;
        msg_order.delete();
        base_x = xfers;
        stage_msg(1, 2);
        stage_msg(2, 1);
        drain("toggle", 400);
        chk("toggle_words", 64'(xfers - base_x), 64'd5);
        chk_order("toggle", 1, 2, 0, 0, 2);
        rdy_mode = 0;

        // q0 len=4 runs dry after payload word 2; q1 waits behind it
        cyc(1);
        msg_order.delete();
        base_rd = rd_cnt[0];
        stage(0, {32'h5A5A_0000, 24'h0, 8'd4});
        stage(0, 64'h1111_2222_3333_4444);
        stage(0, 64'h5555_6666_7777_8888);
        n = 0;
        while (rd_cnt[0] < base_rd + 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach", 64'(rd_cnt[0] - base_rd), 64'd3);
        stage_msg(1, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_no_rd", 64'(q_rd_en), 64'd0);
        end
        stage(0, 64'h9999_AAAA_BBBB_CCCC);
        stage(0, 64'hDDDD_EEEE_FFFF_0001);
        drain("stall", 300);
        chk_order("stall", 0, 1, 0, 0, 2);

        // Maximum length message: 256 words, one last
        cyc(1);
        base_x = xfers;
        base_l = lasts;
        stage_msg(3, 255);
        drain("len255", 3000);
        chk("len255_words", 64'(xfers - base_x), 64'd256);
        chk("len255_lasts", 64'(lasts - base_l), 64'd1);

        // Asynchronous reset mid-payload, then grant search restarts at queue 0
        cyc(1);
        base_x = xfers;
        stage_msg(2, 20);
        n = 0;
        while (xfers < base_x + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_rd_en", 64'(q_rd_en), 64'd0);
        chk("arst_m_valid", 64'(m_valid), 64'd0);
        chk("arst_m_data", m_data, 64'd0);
        chk("arst_m_last", 64'(m_last), 64'd0);
        chk("arst_m_qid", 64'(m_qid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        push_q.delete();
        for (int i = 0; i < NUM_Q; i++) exp_q[i].delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        cyc(1);
        msg_order.delete();
        stage_msg(3, 1);
        stage_msg(1, 2);
        drain("post_rst", 300);
        chk_order("post_rst", 1, 3, 0, 0, 2);

        // Randomized traffic with random back-pressure
        rdy_mode = 2;
        for (int m = 0; m < 40; m++) begin
            stage_msg($urandom_range(0, NUM_Q - 1), $urandom_range(0, 6));
            cyc($urandom_range(1, 5));
        end
        drain("random", 4000);
        rdy_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
